rv32_uart_tx: RTL and testbench

// MMIO UART transmitter on the picorv32 native memory bus, sitting beside the

---
 rtl/rv32_uart_tx_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/rv32_uart_tx.sv | 213 +++++++++++++++++++++
 tb/tb_rv32_uart_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_uart_tx_pkg.sv
// Shared MMIO map and types for the picorv32 UART transmitter slave:
// register offsets, STATUS bit positions, TX FSM states and the deferred-write payload.
package rv32_uart_tx_pkg;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned BYTE_W = 8;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    // STATUS bit positions
    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_BUSY    = 2;
    localparam int unsigned STAT_LVL_LSB = 8;
    localparam int unsigned STAT_LVL_W   = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Write captured at request acceptance, applied on the ack cycle
    typedef struct packed {
        logic             push;
        logic             div_wr;
        logic [1:0]       div_be;
        logic [DIV_W-1:0] wdata;
    } wr_req_t;

    function automatic logic [DIV_W-1:0] div_clamp(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO: dout_c presents the head entry, consumed by pop_i.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_c,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push_c, do_pop_c;

    always_comb begin
        do_push_c = push_i && (!full_q || pop_i);
        do_pop_c  = pop_i && !empty_q;
        count_d   = count_q + LW'(do_push_c) - LW'(do_pop_c);
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == LW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign dout_c  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = count_q;

endmodule

// File: rtl/rv32_uart_tx.sv
// MMIO UART transmitter on the picorv32 native bus: CPU bytes go through a FIFO
// and are serialised 8N1 on uart_tx at a programmable clocks-per-bit divisor.
module rv32_uart_tx
    import rv32_uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned DEFAULT_DIVISOR = 217
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rv32_valid,
    output logic        rv32_ready,
    input  logic [31:0] rv32_addr,
    input  logic [31:0] rv32_wdata,
    input  logic [3:0]  rv32_wstrb,
    output logic [31:0] rv32_rdata,
    output logic        uart_tx
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Bus side
    logic              ready_q, ready_d;
    logic [31:0]       rdata_q, rdata_d;
    wr_req_t           req_q, req_d;
    logic [DIV_W-1:0]  divisor_q, divisor_d;
    logic [1:0]        sel_c;
    logic              is_wr_c, push_req_c;
    logic [31:0]       status_c;

    // TX engine
    tx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  frame_div_q, frame_div_d;
    logic [2:0]        idx_q, idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;

    // FIFO
    logic              fifo_push_c, fifo_pop_c;
    logic [BYTE_W-1:0] fifo_din_c, fifo_dout_c;
    logic              fifo_full, fifo_empty;
    logic [LVL_W-1:0]  fifo_level;

    logic unused_bits;
    assign unused_bits = ^{rv32_addr[31:4], rv32_addr[1:0], rv32_wdata[31:16]};

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (fifo_push_c),
        .pop_i   (fifo_pop_c),
        .din_i   (fifo_din_c),
        .dout_c  (fifo_dout_c),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        status_c = '0;
        status_c[STAT_FULL]  = fifo_full;
        status_c[STAT_EMPTY] = fifo_empty;
        status_c[STAT_BUSY]  = (state_q != TX_IDLE);
        status_c[STAT_LVL_LSB +: STAT_LVL_W] = STAT_LVL_W'(fifo_level);
    end

    // Request decode, registered ack, deferred write application
    always_comb begin
        ready_d     = 1'b0;
        rdata_d     = '0;
        req_d       = '0;
        divisor_d   = divisor_q;
        fifo_push_c = 1'b0;
        fifo_din_c  = req_q.wdata[BYTE_W-1:0];
        sel_c       = rv32_addr[3:2];
        is_wr_c     = |rv32_wstrb;
        push_req_c  = rv32_valid && (sel_c == REG_DATA) && rv32_wstrb[0];

        if (req_q.push) begin
            fifo_push_c = 1'b1;
        end
        if (req_q.div_wr) begin
            if (req_q.div_be[0]) divisor_d[7:0]  = req_q.wdata[7:0];
            if (req_q.div_be[1]) divisor_d[15:8] = req_q.wdata[15:8];
            divisor_d = div_clamp(divisor_d);
        end

        // A push to a full FIFO waits for the pop cycle, pushes there, then acks
        if (rv32_valid && !ready_q && !(push_req_c && fifo_full && !fifo_pop_c)) begin
            ready_d = 1'b1;
            if (push_req_c && fifo_full) begin
                fifo_push_c = 1'b1;
                fifo_din_c  = rv32_wdata[BYTE_W-1:0];
            end else begin
                req_d.push = push_req_c;
            end
            req_d.div_wr = is_wr_c && (sel_c == REG_DIVISOR);
            req_d.div_be = rv32_wstrb[1:0];
            req_d.wdata  = rv32_wdata[DIV_W-1:0];
            if (!is_wr_c) begin
                case (sel_c)
                    REG_STATUS:  rdata_d = status_c;
                    REG_DIVISOR: rdata_d = {16'h0, divisor_q};
                    default:     rdata_d = '0;
                endcase
            end
        end
    end

    // TX FSM next state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_div_d = frame_div_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        fifo_pop_c  = 1'b0;

        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop_c  = 1'b1;
                    shift_d     = fifo_dout_c;
                    frame_div_d = divisor_q;
                    cnt_d       = divisor_q - DIV_W'(1);
                    tx_d        = 1'b0;
                    state_d     = TX_START;
                end
            end
            TX_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = frame_div_q - DIV_W'(1);
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            TX_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = frame_div_q - DIV_W'(1);
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[BYTE_W-1:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            TX_STOP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop_c  = 1'b1;
                        shift_d     = fifo_dout_c;
                        frame_div_d = divisor_q;
                        cnt_d       = divisor_q - DIV_W'(1);
                        tx_d        = 1'b0;
                        state_d     = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            req_q       <= '0;
            divisor_q   <= DIV_W'(DEFAULT_DIVISOR);
            state_q     <= TX_IDLE;
            cnt_q       <= '0;
            frame_div_q <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
        end else begin
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            req_q       <= req_d;
            divisor_q   <= divisor_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_div_q <= frame_div_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
        end
    end

    assign rv32_ready = ready_q;
    assign rv32_rdata = rdata_q;
    assign uart_tx    = tx_q;

endmodule

// File: tb/tb_rv32_uart_tx.sv
// Directed bench for rv32_uart_tx: bus transactions plus a per-cycle uart_tx history
// that frames are checked against after the fact.
module tb_rv32_uart_tx;

    localparam int HIST = 8192;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rv32_valid = 1'b0;
    logic [31:0] rv32_addr = '0;
    logic [31:0] rv32_wdata = '0;
    logic [3:0]  rv32_wstrb = '0;
    logic        rv32_ready;
    logic [31:0] rv32_rdata;
    logic        uart_tx;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdata_leaks = 0;
    int   double_ready = 0;
    logic ready_prev = 1'b0;
    logic tx_hist [HIST];

    rv32_uart_tx #(
        .FIFO_DEPTH      (16),
        .DEFAULT_DIVISOR (217)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rv32_valid (rv32_valid),
        .rv32_ready (rv32_ready),
        .rv32_addr  (rv32_addr),
        .rv32_wdata (rv32_wdata),
        .rv32_wstrb (rv32_wstrb),
        .rv32_rdata (rv32_rdata),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle line history and bus protocol watch
    always @(negedge clk) begin
        if (cyc < HIST) tx_hist[cyc] = uart_tx;
        if (!rv32_ready && rv32_rdata != 32'h0) rdata_leaks++;
        if (rv32_ready && ready_prev) double_ready++;
        ready_prev = rv32_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // One bus request starting at a negedge; returns the ready cycle index
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output int ack);
        int n;
        n = 0;
        rv32_addr  = addr;
        rv32_wdata = wdata;
        rv32_wstrb = strb;
        rv32_valid = 1'b1;
        @(negedge clk);
        while (!rv32_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ack   = cyc;
        rdata = rv32_rdata;
        if (!rv32_ready) chk("bus_timeout", 32'(rv32_ready), 32'd1);
        rv32_valid = 1'b0;
        rv32_wstrb = 4'h0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, output int ack);
        logic [31:0] dummy;
        bus(addr, data, strb, dummy, ack);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        int ack;
        bus(addr, 32'h0, 4'h0, data, ack);
    endtask

    // Expect one 8N1 frame starting at cycle s with d clocks per bit; line high just before
    task automatic chk_frame(input string tag, input int s, input int d, input logic [7:0] b);
        logic [9:0] exp_bits, first_bits, last_bits;
        logic       pre;
        exp_bits = {1'b1, b, 1'b0};
        pre = tx_hist[s - 1];
        for (int k = 0; k < 10; k++) begin
            first_bits[k] = tx_hist[s + k * d];
            last_bits[k]  = tx_hist[s + k * d + d - 1];
        end
        chk(tag, {11'h0, pre, first_bits, last_bits}, {11'h0, 1'b1, exp_bits, exp_bits});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int a, s, s0, r0, zeros;
        logic [7:0] fill [17];

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_ready", 32'(rv32_ready), 32'd0);
        chk("rst_rdata", rv32_rdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        rd(32'h4, r);
        chk("status_after_rst", r, 32'h0000_0002);

        // Reset in the middle of a start bit at the default divisor
        wr(32'h0, 32'h55, 4'h1, a);
        wait_until(a + 100);
        chk("start_bit_low", 32'(uart_tx), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_tx_high", 32'(uart_tx), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        r0 = cyc;
        @(negedge clk);
        rd(32'h4, r);
        chk("status_mid_frame_rst", r, 32'h0000_0002);
        rd(32'h8, r);
        chk("divisor_default", r, 32'd217);
        zeros = 0;
        for (int c = r0; c < cyc; c++) if (tx_hist[c] !== 1'b1) zeros++;
        chk("line_idle_after_rst", 32'(zeros), 32'd0);

        // Single frame 0xA5 at divisor 4
        wr(32'h8, 32'd4, 4'h3, a);
        wr(32'h0, 32'hA5, 4'h1, a);
        wait_until(a + 50);
        s = -1;
        for (int c = a; c < a + 40; c++) if (s < 0 && tx_hist[c] === 1'b0) s = c;
        chk("a5_fall_latency", 32'(s - a), 32'd2);
        chk_frame("frame_a5", a + 2, 4, 8'hA5);
        rd(32'h4, r);
        chk("status_idle_a5", r, 32'h0000_0002);

        // Three back-to-back frames, status sampled in each
        wr(32'h0, 32'h3C, 4'h1, a);
        s = a + 2;
        wr(32'h0, 32'h81, 4'h1, a);
        wr(32'h0, 32'hF0, 4'h1, a);
        rd(32'h4, r);
        chk("status_b2b_f1", r, 32'h0000_0204);
        wait_until(s + 55);
        rd(32'h4, r);
        chk("status_b2b_f2", r, 32'h0000_0104);
        wait_until(s + 95);
        rd(32'h4, r);
        chk("status_b2b_f3", r, 32'h0000_0006);
        wait_until(s + 125);
        rd(32'h4, r);
        chk("status_b2b_done", r, 32'h0000_0002);
        chk_frame("b2b_0", s, 4, 8'h3C);
        chk_frame("b2b_1", s + 40, 4, 8'h81);
        chk_frame("b2b_2", s + 80, 4, 8'hF0);

        // Fill past depth while a slow lead frame (divisor 64) is on the line
        wr(32'h8, 32'd64, 4'h3, a);
        wr(32'h0, 32'hEE, 4'h1, a);
        s0 = a + 2;
        wr(32'h8, 32'd4, 4'h3, a);
        for (int i = 0; i < 17; i++) fill[i] = 8'h10 + 8'(i * 7);
        for (int i = 0; i < 16; i++) wr(32'h0, {24'h0, fill[i]}, 4'h1, a);
        rd(32'h4, r);
        chk("status_full", r, 32'h0000_1005);
        wr(32'h0, {24'h0, fill[16]}, 4'h1, a);
        chk("stall_ack_cycle", 32'(a - s0), 32'd640);
        wait_until(s0 + 640 + 17 * 40 + 5);
        chk_frame("lead_ee", s0, 64, 8'hEE);
        for (int k = 0; k < 17; k++)
            chk_frame($sformatf("fill_%0d", k), s0 + 640 + k * 40, 4, fill[k]);

        // Divisor change mid-frame only affects the next frame
        wr(32'h0, 32'h5A, 4'h1, a);
        s = a + 2;
        wr(32'h8, 32'd8, 4'h3, a);
        wr(32'h0, 32'hC3, 4'h1, a);
        wait_until(s + 130);
        chk_frame("div4_frame", s, 4, 8'h5A);
        chk_frame("div8_frame", s + 40, 8, 8'hC3);
        chk("idle_after_div8", 32'(tx_hist[s + 120]), 32'd1);
        rd(32'h8, r);
        chk("divisor_8", r, 32'h0000_0008);
        wr(32'h8, 32'h0, 4'h3, a);
        rd(32'h8, r);
        chk("divisor_zero_clamp", r, 32'h0000_0001);
        wr(32'h8, 32'h0000_1234, 4'h2, a);
        rd(32'h8, r);
        chk("divisor_byte_lane", r, 32'h0000_1201);

        // Reserved offset, DATA readback, ignored writes
        rd(32'hC, r);
        chk("reserved_read", r, 32'h0);
        wr(32'hC, 32'hFFFF_FFFF, 4'hF, a);
        wr(32'h4, 32'hFFFF_FFFF, 4'hF, a);
        rd(32'h8, r);
        chk("reserved_write_ignored", r, 32'h0000_1201);
        rd(32'h0, r);
        chk("data_read_zero", r, 32'h0);
        wr(32'h0, 32'h77, 4'h2, a);
        rd(32'h4, r);
        chk("no_push_without_strb0", r, 32'h0000_0002);

        chk("rdata_outside_ready", 32'(rdata_leaks), 32'd0);
        chk("ready_single_pulse", 32'(double_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
